// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int SIZE_W     = 2;

  // Arbiter FSM: one outstanding transaction, split into address and data phases.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ADDR = 3'd1,
    I_DATA = 3'd2,
    D_ADDR = 3'd3,
    D_DATA = 3'd4
  } arb_state_e;

  // Access size codes as carried on bus_size / data_size.
  typedef enum logic [SIZE_W-1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // True while the arbiter is presenting an address-phase request.
  function automatic logic is_addr_phase(input arb_state_e s);
    return (s == I_ADDR) || (s == D_ADDR);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_resp_hold_buf.sv
// One-entry response hold register: keeps a returned word until the pipeline advances.
// Latency: word visible the cycle after set_vld; valid drops the cycle after rel/discard.
// Backpressure: none; set_vld wins over a same-cycle release so no response is lost.
module resp_hold_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_vld,
  input  logic [DATA_W-1:0] set_dat,
  input  logic              rel,
  input  logic              discard,
  output logic              buf_vld,
  output logic [DATA_W-1:0] buf_dat
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  // Next-state: release/discard drops valid, a new response reloads; data is kept on release.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rel || discard) begin
      vld_d = 1'b0;
    end
    if (set_vld) begin
      vld_d = 1'b1;
      dat_d = set_dat;
    end
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign buf_vld = vld_q;
  assign buf_dat = dat_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, with per-side response buffers.
// Latency: 3 cycles request to stall release (IDLE, ADDR+addr_ok, DATA+data_ok); one IDLE cycle between transactions.
// Backpressure: holds bus_req and its fields until bus_addr_ok; raises stallreq_* until the buffer holds the word.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_discard,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              data_cancel,
  output logic [DATA_W-1:0] data_rdata,
  input  logic              pipe_stall,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [SIZE_W-1:0] bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic              bus_wr_q, bus_wr_d;
  logic [SIZE_W-1:0] bus_size_q, bus_size_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic ibuf_vld, dbuf_vld;
  logic ibuf_set, dbuf_set;
  logic ineed, dneed;
  logic take_data, take_inst;

  assign ineed = inst_req & ~ibuf_vld & ~inst_discard;
  assign dneed = data_req & ~dbuf_vld & ~data_cancel;

  // Simultaneous needs are resolved by DATA_FIRST; the loser waits for the next IDLE cycle.
  assign take_data = dneed & (DATA_FIRST | ~ineed);
  assign take_inst = ineed & ~take_data;

  // Next-state and registered bus fields; fields only change on IDLE->ADDR so they stay stable under bus_req.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ibuf_set    = 1'b0;
    dbuf_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_data) begin
          state_d     = D_ADDR;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
        end else if (take_inst) begin
          state_d     = I_ADDR;
          bus_wr_d    = 1'b0;
          bus_size_d  = SZ_WORD;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
        end
      end
      I_ADDR: begin
        // A flush before acceptance simply withdraws the fetch; after acceptance the reply must be eaten.
        if (bus_addr_ok) begin
          state_d = I_DATA;
          if (inst_discard) begin
            drop_d = 1'b1;
          end
        end else if (inst_discard) begin
          state_d = IDLE;
        end
      end
      I_DATA: begin
        if (bus_data_ok) begin
          state_d  = IDLE;
          drop_d   = 1'b0;
          ibuf_set = ~drop_q & ~inst_discard;
        end else if (inst_discard) begin
          drop_d = 1'b1;
        end
      end
      D_ADDR: begin
        if (bus_addr_ok) begin
          state_d = D_DATA;
        end
      end
      D_DATA: begin
        // A late cancel does not abort: the access is already on the bus and its result is buffered.
        if (bus_data_ok) begin
          state_d  = IDLE;
          dbuf_set = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bus-field registers; an in-flight transaction is abandoned on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  resp_hold_buf #(.DATA_W(DATA_W)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .set_vld (ibuf_set),
    .set_dat (bus_rdata),
    .rel     (~pipe_stall),
    .discard (inst_discard),
    .buf_vld (ibuf_vld),
    .buf_dat (inst_rdata)
  );

  resp_hold_buf #(.DATA_W(DATA_W)) u_dbuf (
    .clk     (clk),
    .rst     (rst),
    .set_vld (dbuf_set),
    .set_dat (bus_rdata),
    .rel     (~pipe_stall),
    .discard (1'b0),
    .buf_vld (dbuf_vld),
    .buf_dat (data_rdata)
  );

  // bus_req decodes registered state only, so bus inputs never reach it combinationally.
  assign bus_req   = is_addr_phase(state_q);
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  assign stallreq_from_if  = inst_req & ~ibuf_vld;
  assign stallreq_from_mem = dneed;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner sequences, randomized pipeline run.
// Latency: n/a.
// Backpressure: the bench acts as hazard unit and bus slave with random addr_ok/data_ok delays.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_discard;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_cancel;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        pipe_stall, stallreq_from_if, stallreq_from_mem;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_discard      (inst_discard),
    .inst_rdata        (inst_rdata),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_cancel       (data_cancel),
    .data_rdata        (data_rdata),
    .pipe_stall        (pipe_stall),
    .stallreq_from_if  (stallreq_from_if),
    .stallreq_from_mem (stallreq_from_mem),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_size          (bus_size),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0; inst_discard = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
    data_wdata = '0; data_cancel = 1'b0; pipe_stall = 1'b1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Slave memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Randomized request for one pipeline slot.
  task automatic new_request();
    inst_req    = ($urandom_range(0, 3) != 0);
    inst_addr   = 32'hBFC0_0000 + ($urandom_range(0, 255) << 2);
    data_req    = ($urandom_range(0, 1) != 0);
    data_wr     = ($urandom_range(0, 1) != 0);
    data_size   = 2'($urandom_range(0, 2));
    data_addr   = 32'h8000_0000 + $urandom_range(0, 1023);
    data_wdata  = $urandom;
    data_cancel = ($urandom_range(0, 4) == 0);
  endtask

  typedef struct {
    logic ireq;
    logic dreq;
    logic dcan;
    logic idisc;
    logic sif;
    logic smem;
    int   issue;  // 0 none, 1 fetch, 2 data
  } vec_t;

  vec_t vecs[8];

  localparam logic [31:0] TA = 32'hBFC0_0100;
  localparam logic [31:0] TD = 32'h8000_0200;

  int       kind, n_adv, f_cnt, d_cnt, pend_dly;
  logic     first_data, pend, adv;
  logic [31:0] pend_addr, held;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};

    // Reset state, checked while reset is held and after release.
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_fields", {bus_wr, bus_size, bus_addr}, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 0);
    chk("rst_stalls", {stallreq_from_if, stallreq_from_mem}, 0);
    rst = 1'b1;

    // Vector table: IDLE with empty buffers -> stall outputs and which request issues.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      inst_req = vecs[i].ireq; inst_addr = TA;
      data_req = vecs[i].dreq; data_addr = TD; data_size = 2'd2;
      data_cancel = vecs[i].dcan; inst_discard = vecs[i].idisc;
      #1;
      chk($sformatf("vec%0d_stall_if", i), stallreq_from_if, vecs[i].sif);
      chk($sformatf("vec%0d_stall_mem", i), stallreq_from_mem, vecs[i].smem);
      tick();
      kind = !bus_req ? 0 : (bus_addr == TA) ? 1 : (bus_addr == TD) ? 2 : 3;
      chk($sformatf("vec%0d_issue", i), kind, vecs[i].issue);
    end

    // Single fetch with 1-cycle addr_ok and data_ok.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #1;
    chk("s1_stall_idle", stallreq_from_if, 1);
    chk("s1_req_idle", bus_req, 0);
    tick();
    chk("s1_req_addr", bus_req, 1);
    chk("s1_fields", {bus_wr, bus_size, bus_addr}, {1'b0, 2'd2, 32'hBFC0_0000});
    bus_addr_ok = 1'b1;
    tick();
    chk("s1_req_data", bus_req, 0);
    chk("s1_stall_data", stallreq_from_if, 1);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
    tick();
    bus_data_ok = 1'b0;
    chk("s1_stall_done", stallreq_from_if, 0);
    chk("s1_rdata", inst_rdata, 32'h2408_0001);
    pipe_stall = 1'b0;
    tick();
    chk("s1_released", stallreq_from_if, 1);
    inst_req = 1'b0; pipe_stall = 1'b1;

    // Simultaneous fetch and load: data first, fetch after one IDLE cycle.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_addr = 32'h8000_0010; data_size = 2'd2;
    tick();
    chk("s2_first_data", {bus_req, bus_wr, bus_addr}, {2'b10, 32'h8000_0010});
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_data_ok = 1'b0;
    chk("s2_mem_clear", {stallreq_from_mem, stallreq_from_if}, 2'b01);
    chk("s2_idle_gap", bus_req, 0);
    chk("s2_load_data", data_rdata, 32'h1122_3344);
    tick();
    chk("s2_fetch_issue", {bus_req, bus_addr}, {1'b1, 32'hBFC0_0004});
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_1234;
    tick();
    bus_data_ok = 1'b0;
    chk("s2_fetch_done", {stallreq_from_if, inst_rdata}, {1'b0, 32'h0000_1234});

    // Byte store; buffer released on the first pipe_stall=0 edge.
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h8000_0021; data_wdata = 32'h0000_00AB;
    tick();
    chk("s3_store_fields", {bus_req, bus_wr, bus_size}, {2'b11, 2'd0});
    chk("s3_wdata", bus_wdata, 32'h0000_00AB);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    tick();
    bus_data_ok = 1'b0;
    chk("s3_done", stallreq_from_mem, 0);
    tick();
    chk("s3_held", {stallreq_from_mem, bus_req}, 0);
    pipe_stall = 1'b0;
    tick();
    chk("s3_released", stallreq_from_mem, 1);
    data_req = 1'b0; pipe_stall = 1'b1;

    // Flush during I_DATA: late response dropped, next fetch proceeds normally.
    do_reset();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_0000;
    tick(); bus_data_ok = 1'b0; pipe_stall = 1'b0;
    tick(); pipe_stall = 1'b1; inst_addr = 32'hBFC0_0044;
    tick();
    chk("s4_fetch2_issue", {bus_req, bus_addr}, {1'b1, 32'hBFC0_0044});
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; inst_discard = 1'b1; inst_req = 1'b0;
    tick();
    inst_discard = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_data_ok = 1'b0;
    chk("s4_rdata_kept", inst_rdata, 32'h1111_0000);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    #1;
    chk("s4_ibuf_empty", stallreq_from_if, 1);
    tick();
    chk("s4_next_issue", {bus_req, bus_addr}, {1'b1, 32'hBFC0_0100});
    bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2222_0000;
    tick(); bus_data_ok = 1'b0;
    chk("s4_next_rdata", {stallreq_from_if, inst_rdata}, {1'b0, 32'h2222_0000});

    // Long stall after a load, then reset in the middle of D_DATA.
    do_reset();
    data_req = 1'b1; data_addr = 32'h8000_0040; data_size = 2'd2;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick(); bus_data_ok = 1'b0;
    held = data_rdata;
    chk("s5_load", held, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("s5_hold%0d", i), {bus_req, stallreq_from_mem, data_rdata}, {2'b00, 32'hCAFE_F00D});
    end
    pipe_stall = 1'b0; data_req = 1'b0;
    tick();
    pipe_stall = 1'b1; data_req = 1'b1; data_addr = 32'h8000_0080;
    tick(); bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0;
    rst = 1'b0;
    #1;
    chk("s5_rst_req", bus_req, 0);
    chk("s5_rst_fields", {bus_wr, bus_size, bus_addr}, 0);
    chk("s5_rst_rdata", {inst_rdata, data_rdata}, 0);

    // Randomized run: bench is hazard unit and slave; each pipeline advance is checked.
    do_reset();
    pend = 1'b0; adv = 1'b1; n_adv = 0; f_cnt = 0; d_cnt = 0; first_data = 1'b0;
    pend_dly = 0; pend_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (adv) begin
        new_request();
        adv = 1'b0;
      end
      #1;
      bus_data_ok = 1'b0;
      bus_rdata = $urandom;
      if (pend) begin
        if (pend_dly == 0) begin
          bus_data_ok = 1'b1;
          bus_rdata = memf(pend_addr);
          pend = 1'b0;
        end else begin
          pend_dly--;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        bus_data_ok = 1'b1;  // stray strobe outside any data phase
      end
      bus_addr_ok = 1'b0;
      if (bus_req && $urandom_range(0, 2) != 0) begin
        bus_addr_ok = 1'b1;
        pend = 1'b1; pend_addr = bus_addr; pend_dly = $urandom_range(0, 2);
        if (!bus_wr && bus_size == 2'd2 && bus_addr == inst_addr) begin
          if (f_cnt + d_cnt == 0) first_data = 1'b0;
          f_cnt++;
        end else begin
          if (f_cnt + d_cnt == 0) first_data = 1'b1;
          d_cnt++;
          chk("rnd_data_fields", {bus_wr, bus_size, bus_addr}, {data_wr, data_size, data_addr});
          if (data_wr) chk("rnd_wdata", bus_wdata, data_wdata);
        end
      end
      pipe_stall = stallreq_from_if | stallreq_from_mem | ($urandom_range(0, 3) == 0);
      if (!pipe_stall) begin
        adv = 1'b1;
        n_adv++;
        chk("rnd_fetch_count", f_cnt, inst_req ? 1 : 0);
        chk("rnd_data_count", d_cnt, (data_req && !data_cancel) ? 1 : 0);
        if (f_cnt == 1 && d_cnt == 1) chk("rnd_data_first", first_data, 1);
        if (inst_req) chk("rnd_inst_rdata", inst_rdata, memf(inst_addr));
        if (data_req && !data_cancel && !data_wr) chk("rnd_data_rdata", data_rdata, memf(data_addr));
        f_cnt = 0;
        d_cnt = 0;
      end
    end
    chk("rnd_progress", (n_adv > 100) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between instruction fetch (IF) and data access (MEM). Sits between the datapath and the bus bridge.
- Produces stallreq_from_if and stallreq_from_mem for the hazard unit.
- Holds each returned word until the pipeline advances.
- Drops fetch responses invalidated by a flush.

Parameters:
- ADDR_W, 32, bus/request address width
- DATA_W, 32, bus/request data width
- DATA_FIRST, 1, 1 = data request wins simultaneous arbitration, 0 = instruction wins

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  IF wants the instruction at inst_addr
- inst_addr  in  ADDR_W  fetch address (if_pc)
- inst_discard  in  1  flush of IF (if_flush); current fetch result is discarded
- inst_rdata  out  DATA_W  buffered instruction
- data_req  in  1  MEM access request (mem_en)
- data_wr  in  1  1 = store
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  ADDR_W  effective address
- data_wdata  in  DATA_W  store data (pre-aligned)
- data_cancel  in  1  MEM exception/flush; do not issue data_req
- data_rdata  out  DATA_W  buffered load data
- pipe_stall  in  1  pipeline holding this cycle; buffers retained
- stallreq_from_if  out  1  fetch not yet satisfied
- stallreq_from_mem  out  1  data access not yet satisfied
- bus_req  out  1  address-phase request
- bus_wr  out  1  write
- bus_size  out  2  size code
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  response valid
- bus_rdata  in  DATA_W  response data

Behaviour:
- Reset (rst=0, async): state=IDLE; all bus_* outputs, inst_rdata, data_rdata, ibuf_v, dbuf_v, drop = 0. A transaction in flight is abandoned; the bus slave is reset with the core.
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. One outstanding transaction max.
- Needs:
  - ineed = inst_req & ~ibuf_v & ~inst_discard
  - dneed = data_req & ~dbuf_v & ~data_cancel
- IDLE transitions (DATA_FIRST=1): dneed -> D_ADDR, else ineed -> I_ADDR. With DATA_FIRST=0 the order swaps.
- On entry to an ADDR state, register the request into bus_wr/size/addr/wdata. For fetch: wr=0, size=2.
- bus_req = 1 exactly in I_ADDR/D_ADDR; the registered fields are stable while bus_req=1.
- ADDR -> DATA when bus_addr_ok. bus_data_ok is ignored outside DATA states.
- I_DATA, on bus_data_ok -> IDLE:
  - drop=0: ibuf_v=1, inst_rdata=bus_rdata
  - drop=1: response discarded, drop cleared
- D_DATA, on bus_data_ok -> IDLE: dbuf_v=1; data_rdata=bus_rdata (don't-care for stores).
- Stall outputs (combinational):
  - stallreq_from_if = inst_req & ~ibuf_v
  - stallreq_from_mem = data_req & ~dbuf_v & ~data_cancel
- Buffer release: on any edge with pipe_stall=0, ibuf_v and dbuf_v clear, so each buffer is consumed by exactly one pipeline advance.
- inst_discard:
  - clears ibuf_v
  - in I_ADDR before addr_ok: returns to IDLE without completing
  - in I_ADDR with addr_ok, or in I_DATA: sets drop
  - IF stall is not asserted for the discarded fetch
- data_cancel while in D_ADDR/D_DATA: the transaction completes; the result still loads dbuf and is consumed at the next advance.
- Minimum latency from request to stall release is 3 cycles (IDLE, ADDR with addr_ok, DATA with data_ok). The buffer is visible the following cycle.
- Back-to-back: IDLE is re-entered for one cycle between transactions. No combinational path from bus_* inputs to bus_req.

Decomposition:
- Shared package holds: state encoding, size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), bus width constants.
- One natural sub-module, resp_hold_buf: one-entry valid+data register with set/clear/discard. Instantiated twice (instruction, data).

Test Plan:
- Fetch only, addr_ok and data_ok each 1 cycle, inst_addr=0xBFC00000, bus_rdata=0x24080001 -> bus_req high exactly 1 cycle with bus_addr=0xBFC00000, size=2; stallreq_from_if drops after 3 cycles; inst_rdata=0x24080001.
- inst_req and data_req same cycle (load, addr 0x80000010, size 2) -> data issued first, stallreq_from_mem clears before fetch is issued; fetch follows after one IDLE cycle.
- Store, size 0, data_wdata=0x000000AB -> bus_wr=1, bus_size=0, bus_wdata=0xAB; dbuf released on first pipe_stall=0 edge.
- inst_discard in I_DATA, then data_ok with 0xDEADBEEF -> inst_rdata unchanged, ibuf_v=0, next fetch issued normally.
- pipe_stall held 5 cycles after load completes -> data_rdata stable, no reissue; rst asserted mid D_DATA -> bus_req=0, all outputs 0 immediately.
